// File: rtl/pic_8259_pkg.sv
// Shared types and constants for the 8259A interrupt acknowledge path:
// acknowledge state encoding, the default 8080 CALL opcode, OCW3 bit
// positions and the second-INTA vector byte formatter.
package pic_8259_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    ACK3 = 2'd3
  } ack_state_t;

  localparam logic [7:0] CALL_OPCODE_DEFAULT = 8'hCD;

  localparam int OCW3_RIS_BIT = 0;
  localparam int OCW3_RR_BIT  = 1;
  localparam int OCW3_P_BIT   = 2;

  // Byte presented on the second INTA pulse. In 8086 mode it is the full
  // vector (T7..T3 plus level); in 8080 mode it is the low byte of the CALL
  // target, whose layout depends on the 4- or 8-byte call interval.
  function automatic logic [7:0] ack2_byte(
    input logic       is_8086,
    input logic       interval_4,
    input logic [2:0] addr_a7_a5,
    input logic [4:0] vector_t7_t3,
    input logic [2:0] level
  );
    logic [7:0] result;
    if (is_8086) begin
      result = {vector_t7_t3, level};
    end else if (interval_4) begin
      result = {addr_a7_a5, level, 2'b00};
    end else begin
      result = {addr_a7_a5[2:1], level, 3'b000};
    end
    return result;
  endfunction

endpackage

// File: rtl/strobe_edge_detect.sv
// Two-flop sampler for a pin or strobe. The first flop captures the input,
// the second holds the previous sample; rise/fall are one-cycle pulses in
// the cycle after the new level was captured. Both flops reset low, so a
// pin that is already low at reset release produces no falling edge.
module strobe_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic sample;
  logic previous;

  // Capture the strobe and keep one cycle of history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample   <= 1'b0;
      previous <= 1'b0;
    end else begin
      sample   <= strobe;
      previous <= sample;
    end
  end

  assign rise = sample & ~previous;
  assign fall = ~sample & previous;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A control-logic stage: runs the INTA sequence (two pulses for 8086,
// three with a CALL opcode for 8080), drives the vector/opcode byte toward
// the data bus mux, holds the OCW3 read-register select and strobes the
// in-service logic.
// Optional feature macro: POLL_COMMAND_EN (OCW3 poll command and poll read).
module interrupt_ack_sequencer
  import pic_8259_pkg::*;
#(
  parameter logic [7:0] CALL_OPCODE    = CALL_OPCODE_DEFAULT,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic       read,
  input  logic       mode_8086,
  input  logic       call_interval_4,
  input  logic [2:0] vector_low_bits,
  input  logic [7:0] vector_high,
  input  logic       icw1_write,
  input  logic       ocw3_write,
  input  logic [7:0] internal_data_bus,
  input  logic       interrupt_pending,
  input  logic [2:0] highest_level,
  output logic       interrupt_output,
  output logic       out_control_logic_data,
  output logic [7:0] control_logic_data,
  output logic       enable_read_register,
  output logic       read_register_isr_or_irr,
  output logic       latch_in_service,
  output logic       end_of_acknowledge,
  output logic [2:0] acknowledged_level
);

  ack_state_t state;
  logic       inta_rise;
  logic       inta_fall;
  logic       mode_8086_seq;
  logic       seq_drive;
  logic [7:0] seq_data;
  logic [2:0] level_frozen;
  logic       latch_pulse;
  logic       eoa_pulse;
  logic       rr_latched;
  logic       ris_latched;
  logic       poll_taken;
  logic       poll_drive;
  logic [7:0] poll_data;

  strobe_edge_detect u_inta_edge (
    .clock  (clock),
    .reset  (reset),
    .strobe (interrupt_acknowledge_n),
    .rise   (inta_rise),
    .fall   (inta_fall)
  );

`ifdef POLL_COMMAND_EN
  logic poll_pending;
  logic read_rise;
  logic read_fall;
  logic unused_poll_bits;

  strobe_edge_detect u_read_edge (
    .clock  (clock),
    .reset  (reset),
    .strobe (read),
    .rise   (read_rise),
    .fall   (read_fall)
  );

  // A poll command is armed by OCW3 P and consumed at the end of the next
  // read; an INTA falling edge in the same cycle keeps priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_pending <= 1'b0;
    end else if (icw1_write) begin
      poll_pending <= 1'b0;
    end else if (ocw3_write && internal_data_bus[OCW3_P_BIT]) begin
      poll_pending <= 1'b1;
    end else if (poll_taken) begin
      poll_pending <= 1'b0;
    end
  end

  assign poll_taken       = poll_pending && read_fall && (state == IDLE) && !inta_fall;
  assign poll_drive       = poll_pending && read && (state == IDLE);
  assign poll_data        = {interrupt_pending, 4'b0000, highest_level};
  assign unused_poll_bits = ^{read_rise, internal_data_bus[7:3]};
`else
  logic unused_poll_bits;

  assign poll_taken       = 1'b0;
  assign poll_drive       = 1'b0;
  assign poll_data        = 8'h00;
  assign unused_poll_bits = ^{read, internal_data_bus[7:2]};
`endif

  // INTA sequence: advance on each INTA falling edge, load the byte to drive,
  // drop the drive on INTA release and finish on release of the last pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mode_8086_seq <= 1'b0;
      seq_drive     <= 1'b0;
      seq_data      <= 8'h00;
      level_frozen  <= 3'd0;
      latch_pulse   <= 1'b0;
      eoa_pulse     <= 1'b0;
    end else if (icw1_write) begin
      state         <= IDLE;
      mode_8086_seq <= 1'b0;
      seq_drive     <= 1'b0;
      seq_data      <= 8'h00;
      level_frozen  <= 3'd0;
      latch_pulse   <= 1'b0;
      eoa_pulse     <= 1'b0;
    end else begin
      latch_pulse <= 1'b0;
      eoa_pulse   <= 1'b0;
      if (inta_rise) begin
        seq_drive <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (inta_fall) begin
            state         <= ACK1;
            mode_8086_seq <= mode_8086;
            level_frozen  <= interrupt_pending ? highest_level : SPURIOUS_LEVEL;
            latch_pulse   <= 1'b1;
            seq_drive     <= ~mode_8086;
            seq_data      <= mode_8086 ? 8'h00 : CALL_OPCODE;
          end else if (poll_taken) begin
            latch_pulse <= interrupt_pending;
            if (interrupt_pending) begin
              level_frozen <= highest_level;
            end
          end
        end
        ACK1: begin
          if (inta_fall) begin
            state     <= ACK2;
            seq_drive <= 1'b1;
            seq_data  <= ack2_byte(mode_8086_seq, call_interval_4, vector_low_bits,
                                   vector_high[7:3], level_frozen);
          end
        end
        ACK2: begin
          if (inta_fall && !mode_8086_seq) begin
            state     <= ACK3;
            seq_drive <= 1'b1;
            seq_data  <= vector_high;
          end else if (inta_rise && mode_8086_seq) begin
            state     <= IDLE;
            eoa_pulse <= 1'b1;
          end
        end
        ACK3: begin
          if (inta_rise) begin
            state     <= IDLE;
            eoa_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // OCW3 read-register select; RR=0 in the write leaves the selection alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_latched  <= 1'b1;
      ris_latched <= 1'b0;
    end else if (icw1_write) begin
      rr_latched  <= 1'b1;
      ris_latched <= 1'b0;
    end else if (ocw3_write && internal_data_bus[OCW3_RR_BIT]) begin
      rr_latched  <= internal_data_bus[OCW3_RR_BIT];
      ris_latched <= internal_data_bus[OCW3_RIS_BIT];
    end
  end

  assign interrupt_output         = interrupt_pending && (state == IDLE);
  assign out_control_logic_data   = seq_drive | poll_drive;
  assign control_logic_data       = seq_drive  ? seq_data  :
                                    poll_drive ? poll_data : 8'h00;
  assign enable_read_register     = rr_latched;
  assign read_register_isr_or_irr = ris_latched;
  assign latch_in_service         = latch_pulse;
  assign end_of_acknowledge       = eoa_pulse;
  assign acknowledged_level       = level_frozen;

endmodule
